// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA screen limits, coordinate widths and arbiter state encoding.
package vga_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam logic [X_W-1:0] X_SCREEN_PIXELS = 8'd160;
  localparam logic [Y_W-1:0] Y_SCREEN_PIXELS = 7'd120;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/vga_rr_picker.sv
// vga_rr_picker: first requester strictly after ptr, searching cyclically upward; one-hot out.
module vga_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic                 valid
);
  assign valid = |req;
  // Scan farthest-to-nearest so the nearest requester after ptr overwrites the rest.
  always_comb begin
    pick = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) pick = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin sharing of the VGA adapter write port among draw engines.
// Define VGA_ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive grant cycles.
module vga_plot_arbiter import vga_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter logic [X_W-1:0] X_SCREEN_PIXELS = vga_pkg::X_SCREEN_PIXELS,
  parameter logic [Y_W-1:0] Y_SCREEN_PIXELS = vga_pkg::Y_SCREEN_PIXELS
`ifdef VGA_ARB_TIMEOUT_EN
  , parameter logic [15:0] MAX_HOLD = 16'd20000
`endif
) (
  input  logic                   iClock,
  input  logic                   iResetn,
  input  logic [NUM_REQ-1:0]     iReq,
  input  logic [X_W*NUM_REQ-1:0] iX,
  input  logic [Y_W*NUM_REQ-1:0] iY,
  input  logic [C_W*NUM_REQ-1:0] iColour,
  input  logic [NUM_REQ-1:0]     iPlot,
  output logic [NUM_REQ-1:0]     oGnt,
  output logic                   oBusy,
  output logic [X_W-1:0]         oX,
  output logic [Y_W-1:0]         oY,
  output logic [C_W-1:0]         oColour,
  output logic                   oPlot
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [NUM_REQ-1:0] gnt_n, pick;
  logic pick_valid, plot_n, timeout;
  logic [PW-1:0] gidx, gidx_n, ptr, ptr_n, pick_idx;
  logic [X_W-1:0] gx, x_n;
  logic [Y_W-1:0] gy, y_n;
  logic [C_W-1:0] gc, col_n;
  vga_rr_picker #(.N(NUM_REQ)) u_picker (.req(iReq), .ptr(ptr), .pick(pick), .valid(pick_valid));
  assign gx = iX[gidx*X_W +: X_W];
  assign gy = iY[gidx*Y_W +: Y_W];
  assign gc = iColour[gidx*C_W +: C_W];
  assign oBusy = state != S_IDLE;
`ifdef VGA_ARB_TIMEOUT_EN
  logic [15:0] hold;
  always_ff @(posedge iClock)
    hold <= (!iResetn || state != S_GRANT) ? '0 : hold + 16'd1;
  assign timeout = hold == MAX_HOLD - 16'd1;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end
  always_comb begin
    state_n = state;
    gnt_n = oGnt;
    gidx_n = gidx;
    ptr_n = ptr;
    x_n = oX;
    y_n = oY;
    col_n = oColour;
    plot_n = 1'b0;
    case (state)
      S_IDLE: if (pick_valid) begin
        state_n = S_GRANT;
        gnt_n = pick;
        gidx_n = pick_idx;
      end
      S_GRANT: begin
        x_n = gx;
        y_n = gy;
        col_n = gc;
        // The pixel presented on the releasing edge is deliberately discarded.
        if (!iReq[gidx] || timeout) begin
          state_n = S_RELEASE;
          gnt_n = '0;
          ptr_n = gidx;
        end else plot_n = iPlot[gidx] && gx < X_SCREEN_PIXELS && gy < Y_SCREEN_PIXELS;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state <= S_IDLE;
      oGnt <= '0;
      gidx <= '0;
      ptr <= PW'(NUM_REQ - 1);
      oX <= '0;
      oY <= '0;
      oColour <= '0;
      oPlot <= 1'b0;
    end else begin
      state <= state_n;
      oGnt <= gnt_n;
      gidx <= gidx_n;
      ptr <= ptr_n;
      oX <= x_n;
      oY <= y_n;
      oColour <= col_n;
      oPlot <= plot_n;
    end
  end
endmodule
